mcm_product_accumulator: RTL and testbench



---
 rtl/mcm_product_accumulator.sv | 94 +++++++++
 tb/tb_mcm_product_accumulator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mcm_product_accumulator.sv
// Accumulates COUNT signed products per block into a wide sum and presents the
// block result on a registered valid/ready port, with early flush and overflow flag.
module mcm_product_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int COUNT     = 8,
  localparam int CW       = $clog2(COUNT + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data0,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_data0,
  output logic [CW-1:0]        o_count,
  output logic                 o_overflow
);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]           state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 ovf;

  logic [ACC_WIDTH-1:0] operand;
  logic [ACC_WIDTH-1:0] sum;
  logic                 ovf_now;
  logic                 accept;
  logic                 close;
  logic [ACC_WIDTH-1:0] final_sum;
  logic [CW-1:0]        final_cnt;
  logic                 final_ovf;

  // Both handshake outputs decode directly from the state register, so they
  // carry no combinational path from any input.
  assign o_ready = (state == S_ACCUM);
  assign o_valid = (state == S_HOLD);

  assign operand = ACC_WIDTH'($signed(i_data0));
  assign sum     = acc + operand;
  assign ovf_now = (acc[ACC_WIDTH-1] == operand[ACC_WIDTH-1]) &&
                   (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  assign accept  = i_valid && o_ready;

  // A flush with an empty block only closes if a sample lands in the same cycle.
  assign close = (accept && (cnt == CW'(COUNT - 1))) ||
                 (i_flush && o_ready && ((cnt != '0) || accept));

  assign final_sum = accept ? sum : acc;
  assign final_cnt = accept ? cnt + CW'(1) : cnt;
  assign final_ovf = ovf || (accept && ovf_now);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_ACCUM;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      o_data0    <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        S_ACCUM: begin
          if (close) begin
            o_data0    <= final_sum;
            o_count    <= final_cnt;
            o_overflow <= final_ovf;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            state      <= S_HOLD;
          end else if (accept) begin
            acc <= sum;
            cnt <= cnt + CW'(1);
            ovf <= ovf || ovf_now;
          end
        end
        default: begin
          // Result registers hold until the downstream handshake completes.
          if (i_ready) state <= S_ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcm_product_accumulator.sv
// Directed bench for mcm_product_accumulator across three parameterisations:
// COUNT=4/ACC=40, COUNT=2/ACC=32 and COUNT=8/ACC=40.
module tb_mcm_product_accumulator;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  int tests  = 0;
  int failed = 0;

  // Instance A: COUNT=4, ACC_WIDTH=40
  logic        a_valid = 0, a_flush = 0, a_ready_in = 0;
  logic [31:0] a_din = '0;
  logic        a_ready, a_vout, a_ovf;
  logic [39:0] a_dout;
  logic [2:0]  a_cnt;

  // Instance B: COUNT=2, ACC_WIDTH=32
  logic        b_valid = 0, b_flush = 0, b_ready_in = 0;
  logic [31:0] b_din = '0;
  logic        b_ready, b_vout, b_ovf;
  logic [31:0] b_dout;
  logic [1:0]  b_cnt;

  // Instance C: COUNT=8, ACC_WIDTH=40
  logic        c_valid = 0, c_flush = 0, c_ready_in = 0;
  logic [31:0] c_din = '0;
  logic        c_ready, c_vout, c_ovf;
  logic [39:0] c_dout;
  logic [3:0]  c_cnt;

  mcm_product_accumulator #(.WIDTH(32), .ACC_WIDTH(40), .COUNT(4)) u_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(a_valid), .o_ready(a_ready),
    .i_data0(a_din), .i_flush(a_flush), .o_valid(a_vout), .i_ready(a_ready_in),
    .o_data0(a_dout), .o_count(a_cnt), .o_overflow(a_ovf));

  mcm_product_accumulator #(.WIDTH(32), .ACC_WIDTH(32), .COUNT(2)) u_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(b_valid), .o_ready(b_ready),
    .i_data0(b_din), .i_flush(b_flush), .o_valid(b_vout), .i_ready(b_ready_in),
    .o_data0(b_dout), .o_count(b_cnt), .o_overflow(b_ovf));

  mcm_product_accumulator #(.WIDTH(32), .ACC_WIDTH(40), .COUNT(8)) u_c (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(c_valid), .o_ready(c_ready),
    .i_data0(c_din), .i_flush(c_flush), .o_valid(c_vout), .i_ready(c_ready_in),
    .o_data0(c_dout), .o_count(c_cnt), .o_overflow(c_ovf));

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    check("rst_a_valid", 64'(a_vout), 64'd0);
    check("rst_a_data",  64'(a_dout), 64'd0);
    check("rst_a_count", 64'(a_cnt),  64'd0);
    check("rst_a_ovf",   64'(a_ovf),  64'd0);
    i_rst = 1'b0;
    step();
    check("rst_a_ready", 64'(a_ready), 64'd1);

    // Test 1: four positive products back-to-back
    a_valid = 1; a_din = 32'd1532;  step();
    a_din = 32'd3064; step();
    a_din = 32'd4596; step();
    check("t1_not_yet_valid", 64'(a_vout), 64'd0);
    a_din = 32'd6128; step();
    a_valid = 0;
    check("t1_valid", 64'(a_vout),  64'd1);
    check("t1_ready", 64'(a_ready), 64'd0);
    check("t1_data",  64'(a_dout),  64'd15320);
    check("t1_count", 64'(a_cnt),   64'd4);
    check("t1_ovf",   64'(a_ovf),   64'd0);
    a_ready_in = 1; step(); a_ready_in = 0;
    check("t1_release_valid", 64'(a_vout),  64'd0);
    check("t1_release_ready", 64'(a_ready), 64'd1);

    // Test 2: four negative products
    a_valid = 1; a_din = 32'hFFFFFA04;
    repeat (4) step();
    a_din = 32'd1532;
    check("t2_valid", 64'(a_vout), 64'd1);
    check("t2_data",  64'(a_dout), 64'h00FFFFFFE810);
    check("t2_count", 64'(a_cnt),  64'd4);
    check("t2_ovf",   64'(a_ovf),  64'd0);

    // Test 3: backpressure with i_valid held high
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_ready", 64'(a_ready), 64'd0);
      check("t3_hold_data",  64'(a_dout),  64'h00FFFFFFE810);
    end
    a_valid = 0; a_ready_in = 1; step(); a_ready_in = 0;
    check("t3_release_valid", 64'(a_vout),  64'd0);
    check("t3_release_ready", 64'(a_ready), 64'd1);

    // Test 4: early flush after two samples, then flush on empty block
    a_valid = 1; a_din = 32'd1532; repeat (2) step();
    a_valid = 0; a_flush = 1; step(); a_flush = 0;
    check("t4_valid", 64'(a_vout), 64'd1);
    check("t4_data",  64'(a_dout), 64'd3064);
    check("t4_count", 64'(a_cnt),  64'd2);
    a_ready_in = 1; step(); a_ready_in = 0;
    a_flush = 1; step(); a_flush = 0;
    check("t4_empty_flush", 64'(a_vout), 64'd0);
    step();
    check("t4_empty_flush_later", 64'(a_vout), 64'd0);

    // Flush coinciding with an accept on an empty block closes a 1-sample block
    a_valid = 1; a_flush = 1; a_din = 32'd100; step();
    a_valid = 0; a_flush = 0;
    check("t4_flush_accept_valid", 64'(a_vout), 64'd1);
    check("t4_flush_accept_data",  64'(a_dout), 64'd100);
    check("t4_flush_accept_count", 64'(a_cnt),  64'd1);
    a_ready_in = 1; step(); a_ready_in = 0;

    // Test 5: signed overflow in a 32-bit accumulator
    b_valid = 1; b_din = 32'h7FFFFFFF; repeat (2) step();
    b_valid = 0;
    check("t5_valid", 64'(b_vout), 64'd1);
    check("t5_data",  64'(b_dout), 64'hFFFFFFFE);
    check("t5_count", 64'(b_cnt),  64'd2);
    check("t5_ovf",   64'(b_ovf),  64'd1);
    b_ready_in = 1; step(); b_ready_in = 0;
    b_valid = 1; b_din = 32'd1; step();
    b_din = 32'd2; step();
    b_valid = 0;
    check("t5_next_data", 64'(b_dout), 64'd3);
    check("t5_next_ovf",  64'(b_ovf),  64'd0);
    b_ready_in = 1; step(); b_ready_in = 0;

    // Test 6: reset mid-block discards partial sum
    c_valid = 1; c_din = 32'd1532; repeat (3) step();
    c_valid = 0;
    i_rst = 1; #2;
    check("t6_rst_valid", 64'(c_vout), 64'd0);
    step(); i_rst = 0; step();
    c_valid = 1; repeat (7) step();
    check("t6_not_yet_valid", 64'(c_vout), 64'd0);
    step(); c_valid = 0;
    check("t6_valid", 64'(c_vout), 64'd1);
    check("t6_data",  64'(c_dout), 64'd12256);
    check("t6_count", 64'(c_cnt),  64'd8);

    // Reset while a result is pending drops it without a handshake
    i_rst = 1; #2;
    check("t6_hold_rst_valid", 64'(c_vout),  64'd0);
    check("t6_hold_rst_data",  64'(c_dout),  64'd0);
    check("t6_hold_rst_count", 64'(c_cnt),   64'd0);
    step(); i_rst = 0; step();
    check("t6_post_rst_ready", 64'(c_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
